// File: rtl/ram_sp_arb.sv
// Two-requester arbiter for the single-port data RAM: requester 0 has fixed
// priority, requester 1 is forced through after MAX_WAIT consecutive denials.
module ram_sp_arb #(
   parameter int ADDR_MSB = 6,
   parameter int MEM_SIZE = 256,
   parameter int MAX_WAIT = 4
) (
   input  logic              mclk,
   input  logic              rst_n,
   input  logic              p0_req,
   input  logic [ADDR_MSB:0] p0_addr,
   input  logic [15:0]       p0_din,
   input  logic [1:0]        p0_wen,
   input  logic              p1_req,
   input  logic [ADDR_MSB:0] p1_addr,
   input  logic [15:0]       p1_din,
   input  logic [1:0]        p1_wen,
   output logic              p0_gnt,
   output logic              p1_gnt,
   output logic              p0_rdv,
   output logic              p1_rdv,
   output logic [15:0]       p0_dout,
   output logic [15:0]       p1_dout,
   output logic              ram_cen,
   output logic [ADDR_MSB:0] ram_addr,
   output logic [15:0]       ram_din,
   output logic [1:0]        ram_wen,
   input  logic [15:0]       ram_dout,
   output logic              arb_err
);

   localparam logic [3:0]          MAX_W = 4'(MAX_WAIT);
   localparam logic [ADDR_MSB+1:0] WORDS = (ADDR_MSB+2)'(MEM_SIZE / 2);

   logic [3:0] wait_cnt_q, wait_cnt_d;
   logic       rd_vld_q, rd_vld_d;
   logic       rd_own_q, rd_own_d;
   logic       rng_err_q, rng_err_d;
   logic       p0_win, p1_win, any_win;

   // Grants are held off while reset is asserted so the RAM stays idle.
   assign p1_win  = rst_n & p1_req & (~p0_req | (wait_cnt_q == MAX_W));
   assign p0_win  = rst_n & p0_req & ~p1_win;
   assign any_win = p0_win | p1_win;

   assign p0_gnt = p0_win;
   assign p1_gnt = p1_win;

   always_comb begin
      ram_cen  = 1'b1;
      ram_addr = '0;
      ram_din  = 16'h0000;
      ram_wen  = 2'b11;
      if (p1_win) begin
         ram_cen  = 1'b0;
         ram_addr = p1_addr;
         ram_din  = p1_din;
         ram_wen  = p1_wen;
      end else if (p0_win) begin
         ram_cen  = 1'b0;
         ram_addr = p0_addr;
         ram_din  = p0_din;
         ram_wen  = p0_wen;
      end
   end

   always_comb begin
      wait_cnt_d = 4'd0;
      if (p1_req && !p1_win)
         wait_cnt_d = (wait_cnt_q == MAX_W) ? wait_cnt_q : wait_cnt_q + 4'd1;
      rd_vld_d  = any_win & (ram_wen == 2'b11);
      rd_own_d  = p1_win;
      rng_err_d = any_win & ({1'b0, ram_addr} >= WORDS);
   end

   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt_q <= 4'd0;
         rd_vld_q   <= 1'b0;
         rd_own_q   <= 1'b0;
         rng_err_q  <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         rd_vld_q   <= rd_vld_d;
         rd_own_q   <= rd_own_d;
         rng_err_q  <= rng_err_d;
      end
   end

   assign p0_rdv  = rd_vld_q & ~rd_own_q;
   assign p1_rdv  = rd_vld_q & rd_own_q;
   // Out-of-range reads still return a valid pulse, but never RAM contents.
   assign p0_dout = (p0_rdv && !rng_err_q) ? ram_dout : 16'h0000;
   assign p1_dout = (p1_rdv && !rng_err_q) ? ram_dout : 16'h0000;
   assign arb_err = rng_err_q;

endmodule

// File: tb/tb_ram_sp_arb.sv
// Directed bench for ram_sp_arb with a behavioural 64-word RAM that
// registers its address and ignores out-of-range writes.
module tb_ram_sp_arb;

   logic        mclk;
   logic        rst_n;
   logic        p0_req, p1_req;
   logic [6:0]  p0_addr, p1_addr;
   logic [15:0] p0_din, p1_din;
   logic [1:0]  p0_wen, p1_wen;
   logic        p0_gnt, p1_gnt, p0_rdv, p1_rdv;
   logic [15:0] p0_dout, p1_dout;
   logic        ram_cen;
   logic [6:0]  ram_addr;
   logic [15:0] ram_din;
   logic [1:0]  ram_wen;
   logic [15:0] ram_dout;
   logic        arb_err;

   int checks;
   int failures;

   ram_sp_arb #(.ADDR_MSB(6), .MEM_SIZE(128), .MAX_WAIT(4)) dut (
      .mclk(mclk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_addr(p0_addr), .p0_din(p0_din), .p0_wen(p0_wen),
      .p1_req(p1_req), .p1_addr(p1_addr), .p1_din(p1_din), .p1_wen(p1_wen),
      .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rdv(p0_rdv), .p1_rdv(p1_rdv),
      .p0_dout(p0_dout), .p1_dout(p1_dout),
      .ram_cen(ram_cen), .ram_addr(ram_addr), .ram_din(ram_din),
      .ram_wen(ram_wen), .ram_dout(ram_dout), .arb_err(arb_err)
   );

   // clock
   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   // RAM model, preloaded with 16'h1000 + index on the first edge
   logic [15:0] mem [0:63];
   logic [6:0]  mem_addr_q;
   logic        preload;

   always @(posedge mclk) begin
      if (preload) begin
         for (int i = 0; i < 64; i++) mem[i] <= 16'h1000 + 16'(i);
      end else if (!ram_cen) begin
         mem_addr_q <= ram_addr;
         if (ram_addr < 7'd64) begin
            if (!ram_wen[1]) mem[ram_addr[5:0]][15:8] <= ram_din[15:8];
            if (!ram_wen[0]) mem[ram_addr[5:0]][7:0]  <= ram_din[7:0];
         end
      end
   end
   assign ram_dout = (mem_addr_q < 7'd64) ? mem[mem_addr_q[5:0]] : 16'hDEAD;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge mclk);
      #1;
   endtask

   task automatic set_p0(input logic req, input logic [6:0] addr, input logic [15:0] din, input logic [1:0] wen);
      p0_req = req; p0_addr = addr; p0_din = din; p0_wen = wen;
   endtask

   task automatic set_p1(input logic req, input logic [6:0] addr, input logic [15:0] din, input logic [1:0] wen);
      p1_req = req; p1_addr = addr; p1_din = din; p1_wen = wen;
   endtask

   task automatic idle();
      set_p0(1'b0, 7'd0, 16'h0, 2'b11);
      set_p1(1'b0, 7'd0, 16'h0, 2'b11);
   endtask

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   int pat_g1 [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
   int pat_r1 [8]  = '{1, 1, 0, 1, 1, 1, 1, 1};
   int pat_w1 [8]  = '{0, 0, 0, 0, 0, 0, 0, 1};

   initial begin
      int prev;
      checks   = 0;
      failures = 0;
      preload  = 1'b1;
      rst_n    = 1'b0;

      // reset with both requesters active
      set_p0(1'b1, 7'd5, 16'h1111, 2'b00);
      set_p1(1'b1, 7'd6, 16'h2222, 2'b00);
      step();
      preload = 1'b0;
      @(negedge mclk);
      check("rst_p0_gnt", 32'(p0_gnt), 32'd0);
      check("rst_p1_gnt", 32'(p1_gnt), 32'd0);
      check("rst_cen", 32'(ram_cen), 32'd1);
      check("rst_wen", 32'(ram_wen), 32'd3);
      check("rst_p0_rdv", 32'(p0_rdv), 32'd0);
      check("rst_p1_rdv", 32'(p1_rdv), 32'd0);
      check("rst_arb_err", 32'(arb_err), 32'd0);
      idle();
      step();
      rst_n = 1'b1;

      // word write then read on requester 0
      set_p0(1'b1, 7'd3, 16'hA5A5, 2'b00);
      @(negedge mclk);
      check("wr_p0_gnt", 32'(p0_gnt), 32'd1);
      check("wr_cen", 32'(ram_cen), 32'd0);
      check("wr_addr", 32'(ram_addr), 32'd3);
      check("wr_din", 32'(ram_din), 32'hA5A5);
      step();
      set_p0(1'b1, 7'd3, 16'h0000, 2'b11);
      @(negedge mclk);
      check("wr_no_rdv", 32'(p0_rdv), 32'd0);
      step();
      idle();
      @(negedge mclk);
      check("rd_p0_rdv", 32'(p0_rdv), 32'd1);
      check("rd_p0_dout", 32'(p0_dout), 32'hA5A5);
      check("rd_p1_rdv", 32'(p1_rdv), 32'd0);
      check("idle_cen", 32'(ram_cen), 32'd1);
      check("idle_addr", 32'(ram_addr), 32'd0);
      step();
      @(negedge mclk);
      check("rd_pulse_end", 32'(p0_rdv), 32'd0);

      // byte writes on requester 1
      set_p1(1'b1, 7'd3, 16'h12FF, 2'b01);
      step();
      set_p1(1'b1, 7'd3, 16'h0000, 2'b11);
      step();
      idle();
      @(negedge mclk);
      check("hb_p1_rdv", 32'(p1_rdv), 32'd1);
      check("hb_p1_dout", 32'(p1_dout), 32'h12A5);
      check("hb_p0_dout", 32'(p0_dout), 32'h0000);
      set_p1(1'b1, 7'd3, 16'hFF34, 2'b10);
      step();
      set_p1(1'b1, 7'd3, 16'h0000, 2'b11);
      step();
      idle();
      @(negedge mclk);
      check("lb_p1_dout", 32'(p1_dout), 32'h1234);
      step();

      // continuous contention: 0,0,0,0,1 repeating
      set_p0(1'b1, 7'd1, 16'h0, 2'b11);
      set_p1(1'b1, 7'd2, 16'h0, 2'b11);
      prev = -1;
      for (int i = 0; i < 10; i++) begin
         @(negedge mclk);
         check($sformatf("cont_g0_%0d", i), 32'(p0_gnt), 32'(pat_g1[i] == 0));
         check($sformatf("cont_g1_%0d", i), 32'(p1_gnt), 32'(pat_g1[i] == 1));
         if (prev >= 0) begin
            check($sformatf("cont_rdv0_%0d", i), 32'(p0_rdv), 32'(prev == 0));
            check($sformatf("cont_rdv1_%0d", i), 32'(p1_rdv), 32'(prev == 1));
            check($sformatf("cont_dout_%0d", i), 32'(prev == 1 ? p1_dout : p0_dout),
                  prev == 1 ? 32'h1002 : 32'h1001);
         end
         prev = pat_g1[i];
         step();
      end
      idle();
      @(negedge mclk);
      check("cont_last_rdv1", 32'(p1_rdv), 32'd1);
      check("cont_last_dout", 32'(p1_dout), 32'h1002);
      step();

      // dropping p1_req mid-wait restarts the count
      for (int i = 0; i < 8; i++) begin
         set_p0(1'b1, 7'd1, 16'h0, 2'b11);
         set_p1(pat_r1[i] == 1, 7'd2, 16'h0, 2'b11);
         @(negedge mclk);
         check($sformatf("drop_g1_%0d", i), 32'(p1_gnt), 32'(pat_w1[i]));
         step();
      end
      idle();
      step();

      // out-of-range read and write (words 0..63 valid)
      set_p0(1'b1, 7'd64, 16'h0, 2'b11);
      step();
      idle();
      @(negedge mclk);
      check("oor_rd_err", 32'(arb_err), 32'd1);
      check("oor_rd_rdv", 32'(p0_rdv), 32'd1);
      check("oor_rd_dout", 32'(p0_dout), 32'h0000);
      set_p0(1'b1, 7'd64, 16'hBEEF, 2'b00);
      step();
      idle();
      @(negedge mclk);
      check("oor_wr_err", 32'(arb_err), 32'd1);
      check("oor_wr_rdv", 32'(p0_rdv), 32'd0);
      step();
      @(negedge mclk);
      check("oor_err_pulse", 32'(arb_err), 32'd0);

      // reset between a requester 1 read's acceptance and its return
      set_p0(1'b1, 7'd1, 16'h0, 2'b11);
      set_p1(1'b1, 7'd2, 16'h0, 2'b11);
      step();
      step();
      step();
      set_p0(1'b0, 7'd0, 16'h0, 2'b11);
      @(negedge mclk);
      check("mid_wait3", 32'(dut.wait_cnt_q), 32'd3);
      check("mid_p1_gnt", 32'(p1_gnt), 32'd1);
      step();
      rst_n = 1'b0;
      set_p0(1'b1, 7'd1, 16'h0, 2'b11);
      @(negedge mclk);
      check("mid_rst_rdv1", 32'(p1_rdv), 32'd0);
      check("mid_rst_wait", 32'(dut.wait_cnt_q), 32'd0);
      check("mid_rst_g1", 32'(p1_gnt), 32'd0);
      step();
      rst_n = 1'b1;
      @(negedge mclk);
      check("rel_p0_gnt", 32'(p0_gnt), 32'd1);
      check("rel_p1_gnt", 32'(p1_gnt), 32'd0);
      check("rel_rdv1", 32'(p1_rdv), 32'd0);
      step();
      idle();
      @(negedge mclk);
      check("rel_p0_rdv", 32'(p0_rdv), 32'd1);
      check("rel_p0_dout", 32'(p0_dout), 32'h1001);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
